// File: rtl/reflet_dma.sv
// reflet_dma: single-channel byte-copy DMA with an 8-byte control window and a bus-master port.
// Optional interrupt output and ctrl bit1 are built only when REFLET_DMA_INTERRUPT_EN is defined.
module reflet_dma #(
    parameter int unsigned                base_addr_size = 16,
    parameter logic [base_addr_size-1:0]  base_addr      = 16'hFF20
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       interrupt,
    input  logic                       enable,
    input  logic [base_addr_size-1:0]  addr,
    input  logic                       write_en,
    input  logic [7:0]                 data_in,
    output logic [7:0]                 data_out,
    output logic                       m_req,
    input  logic                       m_grant,
    output logic                       m_enable,
    output logic [15:0]                m_addr,
    output logic                       m_write_en,
    output logic [7:0]                 m_data_out,
    input  logic [7:0]                 m_data_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [15:0] r_src;
    logic [15:0] r_dst;
    logic [7:0]  r_len;
    logic        r_dst_fixed;
    logic        r_done;
    logic [15:0] r_cur_src;
    logic [15:0] r_cur_dst;
    logic [8:0]  r_remaining;
    logic [7:0]  r_buffer;
`ifdef REFLET_DMA_INTERRUPT_EN
    logic        r_irq_en;
`endif

    logic [base_addr_size-1:0] w_diff;
    logic [2:0]                w_off;
    logic                      w_hit;
    logic                      w_wr;
    logic                      w_busy;
    logic                      w_start;
    logic                      w_last;
    logic                      w_irq_en;

    // Window need not be 8-aligned, so decode on the offset from base_addr.
    assign w_diff  = addr - base_addr;
    assign w_off   = w_diff[2:0];
    assign w_hit   = enable && (w_diff[base_addr_size-1:3] == '0);
    assign w_wr    = w_hit && write_en;
    assign w_busy  = (r_state != S_IDLE);
    assign w_start = w_wr && (w_off == 3'd5) && data_in[0] && !w_busy;
    assign w_last  = (r_remaining == 9'd1);

`ifdef REFLET_DMA_INTERRUPT_EN
    assign w_irq_en  = r_irq_en;
    assign interrupt = r_done & r_irq_en;
`else
    assign w_irq_en  = 1'b0;
    assign interrupt = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        m_req      = 1'b0;
        m_enable   = 1'b0;
        m_write_en = 1'b0;
        m_addr     = '0;
        m_data_out = '0;
        case (r_state)
            S_IDLE: begin
                if (w_start) w_next = S_REQ;
            end
            S_REQ: begin
                m_req = 1'b1;
                if (m_grant) w_next = S_READ;
            end
            S_READ: begin
                m_req    = 1'b1;
                m_enable = m_grant;
                m_addr   = r_cur_src;
                if (m_grant) w_next = S_WRITE;
            end
            S_WRITE: begin
                m_req      = 1'b1;
                m_enable   = m_grant;
                m_write_en = m_grant;
                m_addr     = r_cur_dst;
                m_data_out = r_buffer;
                if (m_grant) w_next = w_last ? S_IDLE : S_READ;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_src       <= '0;
            r_dst       <= '0;
            r_len       <= '0;
            r_dst_fixed <= 1'b0;
            r_done      <= 1'b0;
            r_cur_src   <= '0;
            r_cur_dst   <= '0;
            r_remaining <= '0;
            r_buffer    <= '0;
`ifdef REFLET_DMA_INTERRUPT_EN
            r_irq_en    <= 1'b0;
`endif
        end else begin
            if (w_wr && !w_busy) begin
                case (w_off)
                    3'd0:    r_src[7:0]  <= data_in;
                    3'd1:    r_src[15:8] <= data_in;
                    3'd2:    r_dst[7:0]  <= data_in;
                    3'd3:    r_dst[15:8] <= data_in;
                    3'd4:    r_len       <= data_in;
                    default: ;
                endcase
            end
            if (w_wr && (w_off == 3'd5)) begin
                r_dst_fixed <= data_in[2];
`ifdef REFLET_DMA_INTERRUPT_EN
                r_irq_en    <= data_in[1];
`endif
            end
            if (w_wr && (w_off == 3'd6) && data_in[1]) r_done <= 1'b0;

            if ((r_state == S_READ) && m_grant) r_buffer <= m_data_in;

            if ((r_state == S_WRITE) && m_grant) begin
                r_cur_src   <= r_cur_src + 16'd1;
                if (!r_dst_fixed) r_cur_dst <= r_cur_dst + 16'd1;
                r_remaining <= r_remaining - 9'd1;
                if (w_last) r_done <= 1'b1;
            end

            // Start is last so it overrides any done-clear in the same cycle.
            if (w_start) begin
                r_cur_src   <= r_src;
                r_cur_dst   <= r_dst;
                r_remaining <= (r_len == 8'd0) ? 9'h100 : {1'b0, r_len};
                r_done      <= 1'b0;
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (w_hit) begin
            case (w_off)
                3'd0:    data_out = r_src[7:0];
                3'd1:    data_out = r_src[15:8];
                3'd2:    data_out = r_dst[7:0];
                3'd3:    data_out = r_dst[15:8];
                3'd4:    data_out = r_len;
                3'd5:    data_out = {5'b0, r_dst_fixed, w_irq_en, 1'b0};
                3'd6:    data_out = {6'b0, r_done, w_busy};
                default: data_out = r_remaining[7:0];
            endcase
        end
    end

endmodule

// File: tb/tb_reflet_dma.sv
// Scoreboard bench for reflet_dma: expected master-port accesses are queued at stimulus time
// and a negedge monitor compares each presented access against the queue.
module tb_reflet_dma;

    localparam logic [15:0] BASE = 16'hFF20;
`ifdef REFLET_DMA_INTERRUPT_EN
    localparam logic IRQ = 1'b1;
`else
    localparam logic IRQ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        enable;
    logic [15:0] addr;
    logic        write_en;
    logic [7:0]  data_in;
    logic [7:0]  data_out;
    logic        m_req;
    logic        m_grant;
    logic        m_enable;
    logic [15:0] m_addr;
    logic        m_write_en;
    logic [7:0]  m_data_out;
    logic [7:0]  m_data_in;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic        we;
        logic [15:0] a;
        logic [7:0]  d;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        mon_e;
    logic [7:0]  mem [0:65535];
    logic [7:0]  v;
    int          n;
    logic        rq;

    always #5 clk = ~clk;

    reflet_dma #(.base_addr_size(16), .base_addr(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .interrupt  (interrupt),
        .enable     (enable),
        .addr       (addr),
        .write_en   (write_en),
        .data_in    (data_in),
        .data_out   (data_out),
        .m_req      (m_req),
        .m_grant    (m_grant),
        .m_enable   (m_enable),
        .m_addr     (m_addr),
        .m_write_en (m_write_en),
        .m_data_out (m_data_out),
        .m_data_in  (m_data_in)
    );

    assign m_data_in = mem[m_addr];

    always @(posedge clk) begin
        if (m_enable && m_write_en) mem[m_addr] <= m_data_out;
    end

    function automatic logic [7:0] pat(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (m_enable === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_access: got we=%b addr=%h expected no access", m_write_en, m_addr);
            end else begin
                mon_e = exp_q.pop_front();
                if (m_write_en !== mon_e.we || m_addr !== mon_e.a || (mon_e.we && m_data_out !== mon_e.d)) begin
                    miscompares++;
                    $display("FAIL access: got we=%b addr=%h data=%h expected we=%b addr=%h data=%h",
                             m_write_en, m_addr, m_data_out, mon_e.we, mon_e.a, mon_e.d);
                end
            end
        end
    end

    task automatic push_copy(input logic [15:0] s, input logic [15:0] d, input int cnt, input logic fixed);
        logic [15:0] sa;
        logic [15:0] da;
        for (int i = 0; i < cnt; i++) begin
            sa = s + 16'(i);
            da = fixed ? d : d + 16'(i);
            exp_q.push_back('{we: 1'b0, a: sa, d: 8'h00});
            exp_q.push_back('{we: 1'b1, a: da, d: pat(sa)});
        end
    endtask

    task automatic bus_write(input logic [2:0] off, input logic [7:0] val);
        enable   = 1'b1;
        write_en = 1'b1;
        addr     = BASE + 16'(off);
        data_in  = val;
        @(posedge clk);
        #1;
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] off, output logic [7:0] val);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + 16'(off);
        @(negedge clk);
        val = data_out;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    task automatic program_regs(input logic [15:0] s, input logic [15:0] d, input logic [7:0] len);
        bus_write(3'd0, s[7:0]);
        bus_write(3'd1, s[15:8]);
        bus_write(3'd2, d[7:0]);
        bus_write(3'd3, d[15:8]);
        bus_write(3'd4, len);
    endtask

    // Polls status each cycle; cnt is the number of negedges until done is seen (bounded by maxc).
    task automatic wait_done(input int maxc, output int cnt, output logic req_at_done);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + 16'd6;
        cnt      = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (data_out[1] !== 1'b1 && cnt < maxc);
        req_at_done = m_req;
        @(posedge clk);
        #1;
        enable = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        enable   = 1'b0;
        write_en = 1'b0;
        addr     = '0;
        data_in  = '0;
        m_grant  = 1'b1;
        for (int i = 0; i < 65536; i++) mem[i] = pat(16'(i));
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_m_req", m_req, 0);
        check("rst_m_enable", m_enable, 0);
        check("rst_m_write_en", m_write_en, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_m_data_out", m_data_out, 0);
        check("rst_interrupt", interrupt, 0);
        check("rst_data_out", data_out, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            bus_read(3'(i), v);
            check($sformatf("rst_reg%0d", i), v, 0);
        end
        bus_write(3'd5, 8'h06);
        bus_read(3'd5, v);
        check("ctrl_rw", v, IRQ ? 16'h06 : 16'h04);
        bus_write(3'd5, 8'h00);

        // 4-byte copy, grant held high
        program_regs(16'h1000, 16'h2000, 8'd4);
        push_copy(16'h1000, 16'h2000, 4, 1'b0);
        bus_write(3'd5, 8'h03);
        @(negedge clk);
        check("t1_req_c1", m_req, 1);
        check("t1_enable_c1", m_enable, 0);
        wait_done(100, n, rq);
        check("t1_done_cycle", 16'(n), 16'd9);
        check("t1_req_at_done", rq, 0);
        check("t1_irq", interrupt, IRQ);
        bus_read(3'd7, v);
        check("t1_remaining", v, 0);
        bus_read(3'd6, v);
        check("t1_status", v, 16'h02);

        // 256-byte copy with source wrap
        program_regs(16'hFFFF, 16'h8000, 8'd0);
        push_copy(16'hFFFF, 16'h8000, 256, 1'b0);
        bus_write(3'd5, 8'h01);
        bus_read(3'd7, v);
        check("t2_remaining_start", v, 0);
        wait_done(700, n, rq);
        check("t2_done_cycle", 16'(n), 16'd513);
        check("t2_req_at_done", rq, 0);
        check("t2_irq_disabled", interrupt, 0);
        bus_read(3'd7, v);
        check("t2_remaining_end", v, 0);
        check("t2_mem_first", mem[16'h8000], pat(16'hFFFF));
        check("t2_mem_wrap", mem[16'h8001], pat(16'h0000));
        check("t2_mem_last", mem[16'h80FF], pat(16'h00FE));

        // Grant dropped for 3 cycles during the second READ
        program_regs(16'h1100, 16'h2100, 8'd4);
        push_copy(16'h1100, 16'h2100, 4, 1'b0);
        bus_write(3'd5, 8'h01);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        m_grant  = 1'b0;
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + 16'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t3_stall_enable%0d", i), m_enable, 0);
            check($sformatf("t3_stall_req%0d", i), m_req, 1);
            check($sformatf("t3_stall_remaining%0d", i), data_out, 16'd3);
            @(posedge clk);
            #1;
        end
        m_grant = 1'b1;
        @(negedge clk);
        check("t3_resume_enable", m_enable, 1);
        wait_done(100, n, rq);
        check("t3_done_cycle", 16'(n), 16'd6);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_mem%0d", i), mem[16'h2100 + 16'(i)], pat(16'h1100 + 16'(i)));
        end

        // Fixed destination
        program_regs(16'h1200, 16'h3000, 8'd3);
        push_copy(16'h1200, 16'h3000, 3, 1'b1);
        bus_write(3'd5, 8'h07);
        wait_done(100, n, rq);
        check("t4_done_cycle", 16'(n), 16'd8);
        check("t4_mem_dst", mem[16'h3000], pat(16'h1202));
        check("t4_mem_untouched", mem[16'h3001], pat(16'h3001));
        check("t4_irq", interrupt, IRQ);

        // Writes while busy, start clears done, done clear
        program_regs(16'h1300, 16'h2300, 8'd4);
        push_copy(16'h1300, 16'h2300, 4, 1'b0);
        bus_write(3'd5, 8'h01);
        bus_read(3'd6, v);
        check("t5_status_after_start", v, 16'h01);
        bus_write(3'd0, 8'h77);
        bus_write(3'd5, 8'h03);
        bus_read(3'd0, v);
        check("t5_src_locked", v, 16'h00);
        wait_done(100, n, rq);
        check("t5_done_cycle", 16'(n), 16'd6);
        check("t5_irq", interrupt, IRQ);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t5_no_restart_req", m_req, 0);
        check("t5_queue_empty", 16'(exp_q.size()), 0);
        bus_write(3'd6, 8'h02);
        bus_read(3'd6, v);
        check("t5_done_cleared", v, 16'h00);
        check("t5_irq_cleared", interrupt, 0);

        // Reset during a WRITE cycle
        program_regs(16'h1400, 16'h2400, 8'd4);
        push_copy(16'h1400, 16'h2400, 2, 1'b0);
        bus_write(3'd5, 8'h01);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(negedge clk);
        check("t6_in_write", m_write_en, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t6_m_req", m_req, 0);
        check("t6_m_enable", m_enable, 0);
        check("t6_m_write_en", m_write_en, 0);
        check("t6_m_addr", m_addr, 0);
        check("t6_m_data_out", m_data_out, 0);
        check("t6_interrupt", interrupt, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus_read(3'd6, v);
        check("t6_status", v, 0);
        bus_read(3'd0, v);
        check("t6_src_lo", v, 0);
        bus_read(3'd7, v);
        check("t6_remaining", v, 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        check("t6_idle_req", m_req, 0);
        check("final_queue_empty", 16'(exp_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
